// File: rtl/ahb_mux_p.sv
// ahb_mux_p: AHB-lite read-data/response mux between one master and NSLAVES slaves.
// Registers the data-phase slave index and returns that slave's HRDATA/HREADY/HRESP
// to the master. A built-in default slave answers decode misses with a two-cycle ERROR.
// Optional feature macro: AHB_MUX_TIMEOUT_EN adds a wait-state limit that forces a
// two-cycle ERROR (and a TIMEOUT_O pulse) when a selected slave stalls too long.
//
// Handshake: an address phase is accepted when M_HREADY_I=1 and M_HTRANS_I is NONSEQ
// or SEQ. The data phase of an accepted transfer completes in the first cycle
// M_HREADY_O=1; the next address phase may be accepted in that same cycle.

module ahb_mux_p #(
    parameter int NSLAVES = 7,
    parameter int SELW    = 3,
    parameter int DW      = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                  HCLK_I,
    input  logic                  HRESET_I,
    input  logic [SELW-1:0]       M_SEL_I,
    input  logic [1:0]            M_HTRANS_I,
    input  logic                  M_HREADY_I,
    output logic                  M_HREADY_O,
    output logic                  M_HRESP_O,
    output logic [DW-1:0]         M_HRDATA_O,
    output logic [NSLAVES-1:0]    S_SEL_O,
    output logic                  S_HREADY_O,
    input  logic [NSLAVES-1:0]    S_HREADY_I,
    input  logic [NSLAVES-1:0]    S_HRESP_I,
    input  logic [NSLAVES*DW-1:0] S_HRDATA_I,
    output logic                  DECERR_O,
    output logic                  TIMEOUT_O,
    output logic [1:0]            dbg_state,
    output logic [SELW-1:0]       dbg_sel_d
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_ERR1 = 2'd2;
    localparam logic [1:0] ST_ERR2 = 2'd3;

    // Highest mapped select value, one bit wider than the select so the compare is safe
    localparam logic [SELW:0] LAST_SEL = (SELW+1)'(NSLAVES);

    // Elaboration-time sanity check of the parameter set
    generate
        if (TIMEOUT < 2 || (2 ** SELW) <= NSLAVES) begin : g_bad_params
            $error("ahb_mux_p: need TIMEOUT>=2 and 2**SELW > NSLAVES");
        end
    endgenerate

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [SELW-1:0] sel_d;
    logic            accept;
    logic            mapped;
    logic            phase_done;
    logic            decerr_nxt;
    logic            timeout_nxt;
    logic            slv_ready;
    logic            slv_resp;
    logic [DW-1:0]   slv_data;
    logic            htrans_unused;

    // Only HTRANS[1] distinguishes NONSEQ/SEQ from IDLE/BUSY
    assign htrans_unused = M_HTRANS_I[0];

    assign accept = M_HREADY_I & M_HTRANS_I[1];
    assign mapped = (M_SEL_I != '0) && ({1'b0, M_SEL_I} <= LAST_SEL);

    // Address-phase decode: one-hot HSEL, all zero for unmapped select values
    always_comb begin
        S_SEL_O = '0;
        for (int k = 0; k < NSLAVES; k++) begin
            S_SEL_O[k] = (M_SEL_I == SELW'(k + 1));
        end
    end

    // Data-phase slave response selected by the registered index
    always_comb begin
        slv_ready = 1'b0;
        slv_resp  = 1'b0;
        slv_data  = '0;
        for (int k = 1; k <= NSLAVES; k++) begin
            if (sel_d == SELW'(k)) begin
                slv_ready = S_HREADY_I[k-1];
                slv_resp  = S_HRESP_I[k-1];
                slv_data  = S_HRDATA_I[(k-1)*DW +: DW];
            end
        end
    end

    // Data-phase slave index, captured with each accepted address phase
    always_ff @(posedge HCLK_I) begin
        if (HRESET_I) begin
            sel_d <= '0;
        end else if (accept) begin
            sel_d <= M_SEL_I;
        end
    end

`ifdef AHB_MUX_TIMEOUT_EN
    localparam int               CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] wait_cnt_nxt;
    logic          wait_expired;

    // The slave has used up its wait-state allowance in this cycle
    assign wait_expired = (state == ST_DATA) && !slv_ready && (wait_cnt == CNT_LAST);

    // Wait counter: cleared on entry to DATA, counts DATA cycles with the slave stalling
    always_comb begin
        wait_cnt_nxt = wait_cnt;
        if (state_nxt == ST_DATA && state != ST_DATA) begin
            wait_cnt_nxt = '0;
        end else if (state == ST_DATA && state_nxt == ST_DATA && !slv_ready) begin
            wait_cnt_nxt = wait_cnt + 1'b1;
        end else if (state_nxt == ST_DATA) begin
            wait_cnt_nxt = '0;
        end
    end

    // Wait counter register
    always_ff @(posedge HCLK_I) begin
        if (HRESET_I) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
        end
    end
`else
    logic wait_expired;

    // Without the timeout feature a stalled slave is waited on indefinitely
    assign wait_expired = 1'b0;
`endif

    // Next-state logic: each completed phase hands over to the next accepted transfer
    always_comb begin
        state_nxt   = state;
        decerr_nxt  = 1'b0;
        timeout_nxt = 1'b0;
        phase_done  = 1'b0;
        case (state)
            ST_IDLE: phase_done = 1'b1;
            ST_DATA: begin
                if (slv_ready) begin
                    phase_done = 1'b1;
                end else if (wait_expired) begin
                    state_nxt   = ST_ERR1;
                    timeout_nxt = 1'b1;
                end
            end
            ST_ERR1: state_nxt = ST_ERR2;
            ST_ERR2: phase_done = 1'b1;
            default: state_nxt = ST_IDLE;
        endcase
        if (phase_done) begin
            if (accept && mapped) begin
                state_nxt = ST_DATA;
            end else if (accept) begin
                state_nxt  = ST_ERR1;
                decerr_nxt = 1'b1;
            end else begin
                state_nxt = ST_IDLE;
            end
        end
    end

    // State register and registered error-entry pulses
    always_ff @(posedge HCLK_I) begin
        if (HRESET_I) begin
            state     <= ST_IDLE;
            DECERR_O  <= 1'b0;
            TIMEOUT_O <= 1'b0;
        end else begin
            state     <= state_nxt;
            DECERR_O  <= decerr_nxt;
            TIMEOUT_O <= timeout_nxt;
        end
    end

    // Master-side response per state; the default slave drives zero data
    always_comb begin
        M_HREADY_O = 1'b1;
        M_HRESP_O  = 1'b0;
        M_HRDATA_O = '0;
        case (state)
            ST_IDLE: begin
                M_HREADY_O = 1'b1;
                M_HRESP_O  = 1'b0;
            end
            ST_DATA: begin
                M_HREADY_O = slv_ready;
                M_HRESP_O  = slv_resp;
                M_HRDATA_O = slv_data;
            end
            ST_ERR1: begin
                M_HREADY_O = 1'b0;
                M_HRESP_O  = 1'b1;
            end
            ST_ERR2: begin
                M_HREADY_O = 1'b1;
                M_HRESP_O  = 1'b1;
            end
            default: begin
                M_HREADY_O = 1'b1;
                M_HRESP_O  = 1'b0;
            end
        endcase
    end

    assign S_HREADY_O = M_HREADY_O;
    assign dbg_state  = state;
    assign dbg_sel_d  = sel_d;

endmodule
